// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller around the combinational shifter
// stage. An accepted request is broken into single-bit shifts, one per step,
// with each shifter result fed back into the accumulator until the requested
// amount has been applied. TICK_DIV slows the steps so they can be watched.

module shift_sequencer #(
   parameter int TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic signed [7:0] d_in,
   input  logic        [2:0] sel,
   input  logic        [2:0] shift_count,
   output logic signed [7:0] stage_din,
   output logic        [2:0] stage_sel,
   output logic        [2:0] stage_count,
   input  logic signed [7:0] stage_dout,
   output logic signed [7:0] d_out,
   output logic              busy,
   output logic              done,
   output logic        [2:0] steps_left
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // The tick counter only has to reach TICK_DIV-1; keep it at least one bit wide
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic        [1:0]        state;
   logic signed [7:0]        acc;
   logic        [2:0]        op_r;
   logic        [TICK_W-1:0] tick;
   logic                     no_shift;

   // Type 000 (none) and 111 (reserved) never move the operand, so they finish at once
   assign no_shift = (sel == 3'b000) || (sel == 3'b111) || (shift_count == 3'd0);

   // The shifter always sees the accumulator and latched type; it shifts by one only in RUN
   assign stage_din   = acc;
   assign stage_sel   = op_r;
   assign stage_count = (state == S_RUN) ? 3'd1 : 3'd0;
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);

   // Sequencer: accept a request, step the shifter every TICK_DIV cycles, then pulse done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         acc        <= '0;
         op_r       <= '0;
         tick       <= '0;
         steps_left <= '0;
         d_out      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc  <= d_in;
                  op_r <= sel;
                  tick <= '0;
                  if (no_shift) begin
                     steps_left <= 3'd0;
                     d_out      <= d_in;
                     state      <= S_DONE;
                  end else begin
                     steps_left <= shift_count;
                     state      <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (tick == TICK_LAST) begin
                  tick       <= '0;
                  acc        <= stage_dout;
                  steps_left <= steps_left - 3'd1;
                  if (steps_left == 3'd1) begin
                     d_out <= stage_dout;
                     state <= S_DONE;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed bench for shift_sequencer. Two instances are
// driven: one stepping every cycle and one with TICK_DIV=4. Each instance has
// its own behavioural shifter stage and a scoreboard queue of expected results
// that a monitor pops whenever done is presented.

module tb_shift_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic       a_start = 1'b0;
   logic [7:0] a_d_in = '0;
   logic [2:0] a_sel = '0;
   logic [2:0] a_cnt = '0;
   logic [7:0] a_stage_din, a_stage_dout, a_d_out;
   logic [2:0] a_stage_sel, a_stage_count, a_steps;
   logic       a_busy, a_done;

   logic       b_start = 1'b0;
   logic [7:0] b_d_in = '0;
   logic [2:0] b_sel = '0;
   logic [2:0] b_cnt = '0;
   logic [7:0] b_stage_din, b_stage_dout, b_d_out;
   logic [2:0] b_stage_sel, b_stage_count, b_steps;
   logic       b_busy, b_done;

   int checks = 0;
   int fails = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic       a_prev_done = 1'b0;
   logic       b_prev_done = 1'b0;

   logic [7:0] din_hist[0:63];
   logic [2:0] steps_first;
   int         busy_cnt;
   int         cyc;

   shift_sequencer #(.TICK_DIV(1)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .d_in(a_d_in), .sel(a_sel),
      .shift_count(a_cnt), .stage_din(a_stage_din), .stage_sel(a_stage_sel),
      .stage_count(a_stage_count), .stage_dout(a_stage_dout), .d_out(a_d_out),
      .busy(a_busy), .done(a_done), .steps_left(a_steps)
   );

   shift_sequencer #(.TICK_DIV(4)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .d_in(b_d_in), .sel(b_sel),
      .shift_count(b_cnt), .stage_din(b_stage_din), .stage_sel(b_stage_sel),
      .stage_count(b_stage_count), .stage_dout(b_stage_dout), .d_out(b_d_out),
      .busy(b_busy), .done(b_done), .steps_left(b_steps)
   );

   // Behavioural shifter stage: n-bit shift built from one-bit moves per type
   function automatic logic [7:0] shifter(input logic [7:0] v, input logic [2:0] s,
                                          input logic [2:0] n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < int'(n); i++) begin
         case (s)
            3'b001, 3'b010: r = {r[6:0], 1'b0};
            3'b011:         r = {1'b0, r[7:1]};
            3'b100:         r = {r[7], r[7:1]};
            3'b101:         r = {r[6:0], r[7]};
            3'b110:         r = {r[0], r[7:1]};
            default:        r = r;
         endcase
      end
      return r;
   endfunction

   // Close the loop: each instance gets its own model of the shifter stage
   always_comb begin
      a_stage_dout = shifter(a_stage_din, a_stage_sel, a_stage_count);
      b_stage_dout = shifter(b_stage_din, b_stage_sel, b_stage_count);
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued result and last one cycle
   always @(negedge clk) begin
      if (!rst && a_done) begin
         check_output("a_done_width", a_prev_done, 1'b0);
         if (exp_a.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL a_extra_done: got d_out 0x%0h, expected no done", a_d_out);
         end else begin
            check_output("a_d_out", a_d_out, exp_a.pop_front());
         end
      end
      if (!rst && b_done) begin
         check_output("b_done_width", b_prev_done, 1'b0);
         if (exp_b.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL b_extra_done: got d_out 0x%0h, expected no done", b_d_out);
         end else begin
            check_output("b_d_out", b_d_out, exp_b.pop_front());
         end
      end
      a_prev_done = a_done;
      b_prev_done = b_done;
   end

   // Issue one request, queue its result, and follow it to completion
   task automatic apply_stimulus(input bit use_b, input logic [7:0] d, input logic [2:0] s,
                                 input logic [2:0] n, input logic [7:0] expv, input int eff);
      int  td;
      bit  ran;
      bit  dn;
      td  = use_b ? 4 : 1;
      ran = 1'b0;
      busy_cnt = 0;
      @(negedge clk);
      if (use_b) begin
         b_d_in = d; b_sel = s; b_cnt = n; b_start = 1'b1;
         exp_b.push_back(expv);
      end else begin
         a_d_in = d; a_sel = s; a_cnt = n; a_start = 1'b1;
         exp_a.push_back(expv);
      end
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
      cyc = 1;
      steps_first = use_b ? b_steps : a_steps;
      forever begin
         din_hist[cyc] = use_b ? b_stage_din : a_stage_din;
         if ((use_b ? b_stage_count : a_stage_count) == 3'd1) ran = 1'b1;
         if (use_b ? b_busy : a_busy) busy_cnt++;
         dn = use_b ? b_done : a_done;
         if (dn || cyc >= 60) break;
         @(negedge clk);
         cyc++;
      end
      check_output("done_latency", cyc, eff * td + 1);
      check_output("busy_cycles", busy_cnt, cyc);
      check_output("run_entered", ran, eff != 0);
      check_output("steps_in_done", use_b ? b_steps : a_steps, 3'd0);
      if (eff != 0) check_output("steps_first_run", steps_first, eff);
      @(negedge clk);
      check_output("idle_after_done", use_b ? b_busy : a_busy, 1'b0);
   endtask

   initial begin
      // Reset state
      #1;
      check_output("rst_busy", a_busy, 1'b0);
      check_output("rst_done", a_done, 1'b0);
      check_output("rst_d_out", a_d_out, 8'h00);
      check_output("rst_stage_count", a_stage_count, 3'd0);
      check_output("rst_steps", a_steps, 3'd0);
      check_output("rst_b_d_out", b_d_out, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Arithmetic right by 3, one step per cycle
      apply_stimulus(1'b0, 8'h96, 3'b100, 3'd3, 8'hF2, 3);
      check_output("asr_acc1", din_hist[1], 8'h96);
      check_output("asr_acc2", din_hist[2], 8'hCB);
      check_output("asr_acc3", din_hist[3], 8'hE5);
      check_output("asr_acc4", din_hist[4], 8'hF2);

      // Rotate left by 5
      apply_stimulus(1'b0, 8'h96, 3'b101, 3'd5, 8'hD2, 5);

      // Zero-step requests finish straight away
      apply_stimulus(1'b0, 8'h5A, 3'b011, 3'd0, 8'h5A, 0);
      apply_stimulus(1'b0, 8'h81, 3'b000, 3'd7, 8'h81, 0);

      // Start pulses during RUN and DONE must be ignored
      @(negedge clk);
      a_d_in = 8'h01; a_sel = 3'b001; a_cnt = 3'd4; a_start = 1'b1;
      exp_a.push_back(8'h10);
      @(negedge clk);
      cyc = 1;
      a_d_in = 8'hFF; a_sel = 3'b100; a_cnt = 3'd7; a_start = 1'b1;
      check_output("busy_in_run", a_busy, 1'b1);
      @(negedge clk);
      cyc = 2;
      a_start = 1'b0;
      while (!a_done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check_output("busy_test_latency", cyc, 5);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      check_output("start_in_done_ignored", a_busy, 1'b0);
      repeat (3) @(negedge clk);
      check_output("busy_test_d_out", a_d_out, 8'h10);
      check_output("busy_test_idle", a_busy, 1'b0);

      // Slow stepping on the TICK_DIV=4 instance
      apply_stimulus(1'b1, 8'h80, 3'b011, 3'd2, 8'h20, 2);
      check_output("slow_acc_k4", din_hist[4], 8'h80);
      check_output("slow_acc_k5", din_hist[5], 8'h40);

      // Reset in the middle of RUN clears outputs without a clock edge
      @(negedge clk);
      a_d_in = 8'h96; a_sel = 3'b101; a_cnt = 3'd5; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      @(negedge clk);
      check_output("pre_reset_busy", a_busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_output("midrst_busy", a_busy, 1'b0);
      check_output("midrst_done", a_done, 1'b0);
      check_output("midrst_d_out", a_d_out, 8'h00);
      #1 rst = 1'b0;

      // A fresh request completes normally after reset
      apply_stimulus(1'b0, 8'h5A, 3'b110, 3'd1, 8'h2D, 1);

      repeat (4) @(negedge clk);
      check_output("a_queue_empty", exp_a.size(), 0);
      check_output("b_queue_empty", exp_b.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
